// File: rtl/mdsa_shear_sorter.sv
// Shearsort engine for an N x N matrix of DW-bit keys: alternating row/column
// odd-even transposition phases, valid/ready on both sides, snake or row-major output.
module mdsa_shear_sorter #(
    parameter int unsigned N      = 8,
    parameter int unsigned DW     = 32,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned LOGN   = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] data_in,
    input  logic              desc,
    input  logic              rowmajor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*DW-1:0] data_out,
    output logic              busy
);

    localparam int unsigned NPH = 2 * LOGN + 1;
    localparam int unsigned SW  = $clog2(N);
    localparam int unsigned PW  = $clog2(NPH);
    localparam logic [SW-1:0] STEP_LAST  = SW'(N - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(NPH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0][N-1:0][DW-1:0] mat_q;
    logic [N-1:0][N-1:0][DW-1:0] mat_step;
    logic [N-1:0][N-1:0][DW-1:0] out_mat;
    logic [SW-1:0]               step_cnt_q;
    logic [PW-1:0]               phase_cnt_q;
    logic                        desc_q;
    logic                        rowmajor_q;
    logic                        accept;
    logic                        do_step;
    logic                        last_step;

    function automatic logic key_gt(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Strict compares keep equal keys in place.
    function automatic logic need_swap(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                                       input logic lo_small);
        return lo_small ? key_gt(lo, hi) : key_gt(hi, lo);
    endfunction

    assign last_step = (phase_cnt_q == PHASE_LAST) && (step_cnt_q == STEP_LAST);

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        do_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SORT;
                end
            end
            SORT: begin
                do_step = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d == SORT);
        end
    end

    // One odd-even transposition step; index r is the row (row phase) or column (column phase).
    always_comb begin
        mat_step = mat_q;
        for (int r = 0; r < int'(N); r++) begin
            for (int i = 0; i < int'(N) - 1; i++) begin
                if ((i % 2) == int'(step_cnt_q[0])) begin
                    if (!phase_cnt_q[0]) begin
                        if (need_swap(mat_q[r][i], mat_q[r][i+1], !(desc_q ^ 1'(r % 2)))) begin
                            mat_step[r][i]   = mat_q[r][i+1];
                            mat_step[r][i+1] = mat_q[r][i];
                        end
                    end else begin
                        if (need_swap(mat_q[i][r], mat_q[i+1][r], !desc_q)) begin
                            mat_step[i][r]   = mat_q[i+1][r];
                            mat_step[i+1][r] = mat_q[i][r];
                        end
                    end
                end
            end
        end
    end

    // Matrix register and phase/step counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mat_q       <= '0;
            step_cnt_q  <= '0;
            phase_cnt_q <= '0;
            desc_q      <= 1'b0;
            rowmajor_q  <= 1'b0;
        end else if (accept) begin
            mat_q       <= data_in;
            step_cnt_q  <= '0;
            phase_cnt_q <= '0;
            desc_q      <= desc;
            rowmajor_q  <= rowmajor;
        end else if (do_step) begin
            mat_q <= mat_step;
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_q  <= '0;
                phase_cnt_q <= phase_cnt_q + PW'(1);
            end else begin
                step_cnt_q <= step_cnt_q + SW'(1);
            end
        end
    end

    // Row-major view un-snakes the odd rows on the way out.
    always_comb begin
        out_mat = mat_q;
        if (rowmajor_q) begin
            for (int r = 1; r < int'(N); r += 2) begin
                for (int c = 0; c < int'(N); c++) begin
                    out_mat[r][c] = mat_q[r][int'(N) - 1 - c];
                end
            end
        end
    end

    assign data_out = out_mat;

endmodule

// File: doc/mdsa_shear_sorter.md
Name: mdsa_shear_sorter

Overview:
- Parametrised, single-clock successor to the fixed 8x8/32-bit MDSA sorter.
- Sorts an N x N matrix of DW-bit keys in place using shearsort: alternating row and column phases, with odd-even transposition inside each phase.
- Replaces the external trans-strobe and feedback transpose with an internal phase/step FSM and a valid/ready handshake on input and output.
- Adds descending order, signed keys and row-major output. Sits between the matrix loader and downstream consumers.

Parameters:
- N, 8, matrix dimension (rows = columns); N >= 2.
- DW, 32, key width in bits.
- SIGNED, 0, 1 = compare keys as two's complement.
- LOGN, $clog2(N), number of column phases; number of row phases is LOGN+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  data_in, desc and rowmajor are valid.
- in_ready  out  1  block is ready to accept a matrix (high in IDLE only).
- data_in  in  N*N*DW  input matrix; element (r,c) is at bits [(r*N+c)*DW +: DW].
- desc  in  1  1 = descending global order; sampled at accept.
- rowmajor  in  1  1 = row-major output; 0 = snake output; sampled at accept.
- out_valid  out  1  data_out holds a sorted matrix.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  N*N*DW  sorted matrix, same layout as data_in.
- busy  out  1  high in SORT.

Behaviour:
- Reset (rst=0, async):
  - state = IDLE; matrix register, phase_cnt, step_cnt, desc_q and rowmajor_q = 0.
  - in_ready = 1, out_valid = 0, busy = 0, data_out = 0.
  - Reset asserted mid-SORT or in DONE aborts the operation; the partial result is discarded.
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - On in_valid & in_ready: load data_in into the matrix register, latch desc and rowmajor, clear both counters, go to SORT.
- SORT: one odd-even transposition step per cycle on all rows (row phase) or all columns (column phase) in parallel.
  - Step parity = step_cnt[0]. Even steps compare index pairs (0,1),(2,3),... Odd steps compare (1,2),(3,4),...
  - Unpaired end elements hold their value.
  - Each phase is exactly N steps.
  - Phase order: row, col, row, col, ..., row. Total NPH = 2*LOGN+1 phases; phase_cnt even = row phase.
  - Row phase direction: row r even = smaller key at lower column index; row r odd = larger key at lower column index.
  - Column phase direction: smaller key at lower row index.
  - desc_q = 1 inverts every comparison.
  - Equal keys are never swapped.
  - SIGNED selects signed or unsigned comparison.
  - step_cnt wraps N-1 -> 0 and increments phase_cnt.
  - On the step with phase_cnt = NPH-1 and step_cnt = N-1: write the final step result and go to DONE.
  - Latency: exactly NPH*N clock edges from the accept edge to the edge that raises out_valid.
- DONE:
  - out_valid = 1.
  - data_out = matrix register, with odd rows column-reversed when rowmajor_q = 1; this reversal is combinational.
  - data_out is held stable while out_ready = 0, with no timeout.
  - On out_valid & out_ready: go to IDLE. in_ready rises the following cycle, giving no same-cycle turnaround.
- in_valid in SORT or DONE is ignored and nothing is latched.
- desc/rowmajor changes after accept have no effect.
- data_out outside DONE = last matrix register contents; consumers must qualify with out_valid.
- No arithmetic beyond comparison; the counters are $clog2(N) and $clog2(NPH) bits wide.

Test Plan:
1. Snake, ascending: N=4, DW=8; data_in row-major 15,14,...,0; desc=0, rowmajor=0.
   - Required: out_valid exactly 20 cycles after accept.
   - Rows {0,1,2,3}, {7,6,5,4}, {8,9,10,11}, {15,14,13,12}.
2. Row-major: same stimulus with rowmajor=1.
   - Required: data_out row-major 0..15.
3. Descending, signed: SIGNED=1, desc=1, rowmajor=1; keys -8..7 shuffled.
   - Required: row-major 7,6,...,-8.
   - Unsigned instance with the same bits: 0xFF (-1) ranks largest.
4. Duplicates/stability: all keys 5, or two 3s among distinct keys.
   - Required: correct multiset, sorted.
   - All-5 input returns unchanged.
5. Handshake:
   - in_valid held during SORT -> not latched, in_ready = 0, busy = 1.
   - out_ready = 0 for 100 cycles in DONE -> data_out stable, out_valid = 1.
   - out_ready pulse -> IDLE, in_ready = 1 next cycle; back-to-back second matrix sorts correctly.
6. Reset mid-sort: assert rst=0 at step 7.
   - Required: outputs immediately go to reset values.
   - After release, a new matrix sorts correctly in 20 cycles.
